// File: rtl/pc_redirect_arb_pkg.sv
// Shared types and helpers for the PC redirect arbiter: the redirect request
// record and the wrap-aware issue age used to order redirects.
package pc_redirect_arb_pkg;

  // The parameterised holder gives each instance a request record sized to its own ID_W.
  virtual class redirect_types #(parameter int ID_W = 8);
    typedef struct packed {
      logic            valid;
      logic [31:0]     pc;
      logic [ID_W-1:0] issue_id;
    } redirect_req_t;
  endclass

  // Distance from head in issue order. Callers truncate the result to their ID
  // width, which makes it the difference modulo 2^ID_WIDTH.
  function automatic logic [31:0] issue_age(input logic [31:0] id, input logic [31:0] head);
    return id - head;
  endfunction

endpackage

// File: rtl/pc_redirect_arb_if.sv
// Redirect sources, head-of-window id and flush in; one registered redirect
// plus the drop counter out.
interface pc_redirect_arb_if #(
  parameter int NUM_SICS  = 4,
  parameter int ID_WIDTH  = 8,
  parameter int CNT_WIDTH = 16
);
  logic [NUM_SICS-1:0]               in_valid;
  logic [NUM_SICS-1:0][31:0]         in_pc;
  logic [NUM_SICS-1:0][ID_WIDTH-1:0] in_issue_id;
  logic [ID_WIDTH-1:0]               head_id;
  logic                              flush;
  logic                              out_valid;
  logic [31:0]                       out_pc;
  logic [ID_WIDTH-1:0]               out_issue_id;
  logic                              out_ready;
  logic [CNT_WIDTH-1:0]              drop_cnt;

  modport master (
    output in_valid, in_pc, in_issue_id, head_id, flush, out_ready,
    input  out_valid, out_pc, out_issue_id, drop_cnt
  );

  modport slave (
    input  in_valid, in_pc, in_issue_id, head_id, flush, out_ready,
    output out_valid, out_pc, out_issue_id, drop_cnt
  );
endinterface

// File: rtl/redirect_oldest_sel.sv
// Combinational min-age picker over the redirect sources. On an age tie the
// lowest index wins. Also reports how many asserted sources lost.
module redirect_oldest_sel
  import pc_redirect_arb_pkg::*;
#(
  parameter int NUM_SICS = 4,
  parameter int ID_WIDTH = 8,
  parameter int IDX_W    = (NUM_SICS > 1) ? $clog2(NUM_SICS) : 1,
  parameter int LCNT_W   = $clog2(NUM_SICS + 1)
) (
  input  redirect_types#(ID_WIDTH)::redirect_req_t [NUM_SICS-1:0] req,
  input  logic [ID_WIDTH-1:0]                                    head_id,
  output logic                                                   win_valid,
  output logic [IDX_W-1:0]                                       win_idx,
  output logic [ID_WIDTH-1:0]                                    win_age,
  output logic [LCNT_W-1:0]                                      lose_cnt
);

  logic [ID_WIDTH-1:0] age_i;

  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    win_age   = '0;
    lose_cnt  = '0;
    age_i     = '0;
    for (int i = 0; i < NUM_SICS; i++) begin
      if (req[i].valid) begin
        lose_cnt = lose_cnt + LCNT_W'(1);
        age_i    = ID_WIDTH'(issue_age(32'(req[i].issue_id), 32'(head_id)));
        // Strict compare keeps the earlier (lower) index on ties.
        if (!win_valid || (age_i < win_age)) begin
          win_valid = 1'b1;
          win_idx   = IDX_W'(i);
          win_age   = age_i;
        end
      end
    end
    if (win_valid) lose_cnt = lose_cnt - LCNT_W'(1);
  end

endmodule

// File: rtl/pc_redirect_arb.sv
// Keeps the oldest pending PC redirect in a single registered slot, hands it
// to fetch over valid/ready, and counts every redirect it discards.
module pc_redirect_arb
  import pc_redirect_arb_pkg::*;
#(
  parameter int NUM_SICS  = 4,
  parameter int ID_WIDTH  = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  pc_redirect_arb_if.slave bus
);

  localparam int IDX_W  = (NUM_SICS > 1) ? $clog2(NUM_SICS) : 1;
  localparam int LCNT_W = $clog2(NUM_SICS + 1);
  localparam int DW     = $clog2(NUM_SICS + 2);
  localparam int SW     = CNT_WIDTH + DW;

  typedef redirect_types#(ID_WIDTH)::redirect_req_t req_t;

  req_t [NUM_SICS-1:0] req;
  logic                win_valid;
  logic [IDX_W-1:0]    win_idx;
  logic [ID_WIDTH-1:0] win_age;
  logic [LCNT_W-1:0]   lose_cnt;

  logic                held_valid;
  logic [31:0]         held_pc;
  logic [ID_WIDTH-1:0] held_id;
  logic [ID_WIDTH-1:0] held_age;
  logic [CNT_WIDTH-1:0] drop_cnt;

  logic                accept, take, nxt_valid;
  logic [DW-1:0]       drops;
  logic [SW-1:0]       cnt_sum;
  logic [CNT_WIDTH-1:0] cnt_nxt;

  for (genvar g = 0; g < NUM_SICS; g++) begin : g_req
    assign req[g].valid    = bus.in_valid[g];
    assign req[g].pc       = bus.in_pc[g];
    assign req[g].issue_id = bus.in_issue_id[g];
  end

  redirect_oldest_sel #(
    .NUM_SICS (NUM_SICS),
    .ID_WIDTH (ID_WIDTH),
    .IDX_W    (IDX_W),
    .LCNT_W   (LCNT_W)
  ) u_sel (
    .req       (req),
    .head_id   (bus.head_id),
    .win_valid (win_valid),
    .win_idx   (win_idx),
    .win_age   (win_age),
    .lose_cnt  (lose_cnt)
  );

  // Held entry is re-aged every cycle so head_id motion is tracked.
  assign held_age = ID_WIDTH'(issue_age(32'(held_id), 32'(bus.head_id)));
  assign accept   = held_valid && bus.out_ready;

  always_comb begin
    take      = 1'b0;
    nxt_valid = 1'b0;
    drops     = '0;
    if (bus.flush) begin
      // A handshake in the same cycle still counts as delivered, not dropped.
      drops = DW'($countones(bus.in_valid)) + DW'(held_valid && !accept);
    end else if (!held_valid || accept) begin
      take      = win_valid;
      nxt_valid = win_valid;
      drops     = DW'(lose_cnt);
    end else if (win_valid && (win_age < held_age)) begin
      take      = 1'b1;
      nxt_valid = 1'b1;
      drops     = DW'(lose_cnt) + DW'(1);
    end else begin
      nxt_valid = 1'b1;
      drops     = DW'(lose_cnt) + DW'(win_valid);
    end
  end

  assign cnt_sum = SW'(drop_cnt) + SW'(drops);
  assign cnt_nxt = (cnt_sum > SW'({CNT_WIDTH{1'b1}})) ? {CNT_WIDTH{1'b1}} : cnt_sum[CNT_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      held_valid <= 1'b0;
      held_pc    <= '0;
      held_id    <= '0;
      drop_cnt   <= '0;
    end else begin
      held_valid <= nxt_valid;
      drop_cnt   <= cnt_nxt;
      if (take) begin
        held_pc <= req[win_idx].pc;
        held_id <= req[win_idx].issue_id;
      end
    end
  end

  assign bus.out_valid    = held_valid;
  assign bus.out_pc       = held_pc;
  assign bus.out_issue_id = held_id;
  assign bus.drop_cnt     = drop_cnt;

endmodule

// File: tb/tb_pc_redirect_arb.sv
// Directed bench for pc_redirect_arb with a rule-level reference model checked
// every cycle, plus literal expectations at key points of each scenario.
module tb_pc_redirect_arb;
  localparam int NS  = 4;
  localparam int IW  = 8;
  localparam int CW  = 4;
  localparam int CMAX = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_redirect_arb_if #(.NUM_SICS(NS), .ID_WIDTH(IW), .CNT_WIDTH(CW)) bus ();

  pc_redirect_arb #(.NUM_SICS(NS), .ID_WIDTH(IW), .CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one slot, oldest-by-age wins, everything discarded is counted.
  bit          m_valid;
  logic [31:0] m_pc;
  int          m_id;
  int          m_cnt;

  function automatic int age(input int id, input int head);
    return (id - head) & 255;
  endfunction

  always @(posedge clk) begin
    int best, nv, d, hd;
    bit acc, nvld;
    logic [31:0] npc;
    int nid;
    hd   = int'(bus.head_id);
    acc  = m_valid && bus.out_ready;
    best = -1;
    nv   = 0;
    for (int i = 0; i < NS; i++)
      if (bus.in_valid[i]) begin
        nv++;
        if (best < 0 || age(int'(bus.in_issue_id[i]), hd) < age(int'(bus.in_issue_id[best]), hd))
          best = i;
      end
    nvld = m_valid; npc = m_pc; nid = m_id; d = 0;
    if (bus.flush) begin
      nvld = 0;
      d = nv + ((m_valid && !acc) ? 1 : 0);
    end else if (!m_valid || acc) begin
      nvld = (best >= 0);
      d = nv - ((best >= 0) ? 1 : 0);
      if (best >= 0) begin npc = bus.in_pc[best]; nid = int'(bus.in_issue_id[best]); end
    end else if (best >= 0 && age(int'(bus.in_issue_id[best]), hd) < age(m_id, hd)) begin
      d = nv;  // losers plus the displaced entry
      npc = bus.in_pc[best]; nid = int'(bus.in_issue_id[best]);
    end else begin
      d = nv;
    end
    if (rst) begin
      m_valid <= 1'b0; m_pc <= '0; m_id <= 0; m_cnt <= 0;
    end else begin
      m_valid <= nvld; m_pc <= npc; m_id <= nid;
      m_cnt   <= (m_cnt + d > CMAX) ? CMAX : m_cnt + d;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("mdl_valid", 32'(bus.out_valid), 32'(m_valid));
      if (m_valid) begin
        chk("mdl_pc", bus.out_pc, m_pc);
        chk("mdl_id", 32'(bus.out_issue_id), 32'(m_id));
      end
      chk("mdl_drop", 32'(bus.drop_cnt), 32'(m_cnt));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    bus.in_valid = '0;
    bus.in_pc = '0;
    bus.in_issue_id = '0;
    bus.flush = 1'b0;
  endtask

  task automatic put(input int s, input logic [31:0] pc, input logic [7:0] id);
    bus.in_valid[s] = 1'b1;
    bus.in_pc[s] = pc;
    bus.in_issue_id[s] = id;
  endtask

  initial begin
    clr_in();
    bus.head_id = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    step();
    chk_en = 1'b1;
    step();
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_drop", 32'(bus.drop_cnt), 32'd0);
    rst = 1'b0;

    // Single redirect
    bus.out_ready = 1'b1;
    put(2, 32'h0040_0100, 8'h05);
    step(); clr_in();
    chk("t1_valid", 32'(bus.out_valid), 32'd1);
    chk("t1_pc", bus.out_pc, 32'h0040_0100);
    chk("t1_id", 32'(bus.out_issue_id), 32'h05);
    step();
    chk("t1_clear", 32'(bus.out_valid), 32'd0);
    chk("t1_drop", 32'(bus.drop_cnt), 32'd0);

    // Same-cycle pair
    bus.out_ready = 1'b0;
    put(0, 32'h0000_1000, 8'h09);
    put(3, 32'h0000_2000, 8'h04);
    step(); clr_in();
    chk("t2_id", 32'(bus.out_issue_id), 32'h04);
    chk("t2_pc", bus.out_pc, 32'h0000_2000);
    chk("t2_drop", 32'(bus.drop_cnt), 32'd1);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;

    // Replace while stalled, then reject a younger one
    put(0, 32'h0000_3000, 8'h10);
    step(); clr_in();
    chk("t3_id0", 32'(bus.out_issue_id), 32'h10);
    put(1, 32'h0000_3100, 8'h0C);
    step(); clr_in();
    chk("t3_id1", 32'(bus.out_issue_id), 32'h0C);
    chk("t3_drop1", 32'(bus.drop_cnt), 32'd2);
    put(2, 32'h0000_3200, 8'h20);
    step(); clr_in();
    step();
    chk("t3_hold_id", 32'(bus.out_issue_id), 32'h0C);
    chk("t3_hold_pc", bus.out_pc, 32'h0000_3100);
    chk("t3_drop2", 32'(bus.drop_cnt), 32'd3);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;

    // Wrap ordering
    bus.head_id = 8'hFE;
    put(0, 32'h0000_4000, 8'h01);
    put(1, 32'h0000_4100, 8'hFF);
    step(); clr_in();
    chk("t4_id", 32'(bus.out_issue_id), 32'hFF);
    chk("t4_drop", 32'(bus.drop_cnt), 32'd4);

    // Flush with a handshake and an input in the same cycle
    bus.out_ready = 1'b1;
    bus.flush = 1'b1;
    put(0, 32'h0000_4200, 8'h00);
    step(); clr_in();
    bus.out_ready = 1'b0;
    chk("t5_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_drop", 32'(bus.drop_cnt), 32'd5);

    // Equal-age tie goes to the lower index
    bus.head_id = 8'h00;
    put(1, 32'h0000_5100, 8'h07);
    put(3, 32'h0000_5300, 8'h07);
    step(); clr_in();
    chk("tie_pc", bus.out_pc, 32'h0000_5100);
    chk("tie_drop", 32'(bus.drop_cnt), 32'd6);
    bus.flush = 1'b1;
    step(); clr_in();
    chk("fl_valid", 32'(bus.out_valid), 32'd0);
    chk("fl_drop", 32'(bus.drop_cnt), 32'd7);

    // Reset mid-hold
    put(0, 32'h0000_6000, 8'h03);
    step(); clr_in();
    chk("rh_valid", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rh_valid0", 32'(bus.out_valid), 32'd0);
    chk("rh_pc0", bus.out_pc, 32'd0);
    chk("rh_drop0", 32'(bus.drop_cnt), 32'd0);

    // Saturation: 20 drops into a 4-bit counter
    for (int k = 0; k < 5; k++) begin
      bus.flush = 1'b1;
      for (int s = 0; s < NS; s++) put(s, 32'h0000_7000 + 32'(s), 8'(k * 4 + s));
      step();
    end
    clr_in();
    step();
    chk("sat_drop", 32'(bus.drop_cnt), 32'd15);

    // Mixed traffic checked against the model only
    rst = 1'b1; step(); rst = 1'b0;
    for (int k = 0; k < 60; k++) begin
      bus.in_valid    = 4'($urandom_range(0, 15));
      for (int s = 0; s < NS; s++) begin
        bus.in_pc[s]       = $urandom;
        bus.in_issue_id[s] = 8'($urandom_range(0, 255));
      end
      if ((k % 7) == 0) bus.head_id = 8'($urandom_range(0, 255));
      bus.out_ready = 1'($urandom_range(0, 1));
      bus.flush     = ($urandom_range(0, 15) == 0);
      step();
    end
    clr_in();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pc_redirect_arb.md
Name: pc_redirect_arb

Overview:
- Downstream of the execute sub-SICs. Collects their single-cycle pc_redirect pulses (valid, pc, issue_id) and keeps the oldest pending redirect.
- Presents that redirect to fetch through a registered valid/ready interface.
- Holds one entry. An older redirect supersedes a younger pending one; anything younger or equal is dropped and counted.

Parameters:
- NUM_SICS, 4: number of sub-SIC redirect sources.
- ID_WIDTH, 8: issue_id width. IDs wrap modulo 2^ID_WIDTH.
- CNT_WIDTH, 16: width of the saturating drop counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  NUM_SICS  per-SIC pc_redirect_valid pulse.
- in_pc  in  NUM_SICS x 32  per-SIC pc_redirect_pc.
- in_issue_id  in  NUM_SICS x ID_WIDTH  per-SIC pc_redirect_issue_id.
- head_id  in  ID_WIDTH  issue_id of the oldest in-flight instruction (age origin).
- flush  in  1  global pipeline flush; discards the pending entry.
- out_valid  out  1  redirect pending to fetch.
- out_pc  out  32  redirect target.
- out_issue_id  out  ID_WIDTH  issue_id of the redirecting instruction.
- out_ready  in  1  fetch accepts the redirect this cycle.
- drop_cnt  out  CNT_WIDTH  count of discarded redirects.

Behaviour:
- Reset (rst=1 at a clock edge): held_valid=0, out_valid=0, out_pc=0, out_issue_id=0, drop_cnt=0. Reset mid-hold discards the entry with no handshake.
- Age rule: age(x) = (x - head_id) mod 2^ID_WIDTH, unsigned. Smaller age is older. Recompute every cycle, including for the held entry, so that head_id motion is tracked.
- Per-cycle winner (combinational):
  - Among asserted in_valid, pick the minimum age.
  - Equal age: lowest SIC index wins.
  - Every other asserted input is a loser.
- Outputs come straight from registers: out_valid=held_valid, out_pc=held_pc, out_issue_id=held_id.
- Latency: an input pulse at edge N appears on out_valid after edge N+1, i.e. a 1-cycle registered path, no combinational in-to-out path.
- Accept: out_valid && out_ready at the edge clears the held entry. out_valid holds with stable data until accepted, replaced or flushed.
- Next state, in priority order:
  1. flush=1: held_valid<=0. All inputs this cycle are dropped.
  2. Slot is free (empty, or accepted this cycle): capture the winner if any, else held_valid<=0.
  3. Slot occupied and not accepted: capture the winner only if age(winner) < age(held_id). The displaced held entry counts as a drop. Otherwise the winner is dropped.
- Drop counting:
  - Increment drop_cnt by the number of redirects discarded this cycle: losers, rejected winner, displaced held entry, inputs during flush.
  - An accepted entry is not a drop. A held entry cleared by flush is a drop.
  - Saturate at 2^CNT_WIDTH-1. No wrap.
- Wrap: IDs across the 2^ID_WIDTH boundary order correctly via the age rule. Example: head_id=0xFE, id 0x01 has age 3, id 0xFF has age 1, so 0xFF is older.
- Replacing the held entry while out_valid=1 and out_ready=0 is legal. Fetch must sample only on the handshake.

Decomposition:
- Shared package:
  - redirect_req_t struct {valid, pc[31:0], issue_id[ID_WIDTH-1:0]}, parameterised with the same class-typedef style as sic_packet.
  - Age function issue_age(id, head).
- One sub-module: redirect_oldest_sel, a pure combinational NUM_SICS-way min-age selector producing winner index, valid and loser count.
- The hold register, handshake logic and counter stay in pc_redirect_arb.

Test Plan:
- Single redirect: head=0x00, SIC2 valid, pc=0x00400100, id=0x05, out_ready=1.
  -> Next cycle out_valid=1, pc=0x00400100, id=0x05. Cleared after the handshake. drop_cnt=0.
- Same-cycle pair: SIC0 id=0x09 pc=A, SIC3 id=0x04 pc=B, head=0x00.
  -> out shows id 0x04, pc B. drop_cnt=1.
- Replace while stalled: out_ready=0, held id=0x10. Then SIC1 id=0x0C arrives.
  -> Out becomes 0x0C. drop_cnt+1. A later id=0x20 is dropped with drop_cnt+1 and out stays 0x0C.
- Wrap ordering: head=0xFE, SIC0 id=0x01, SIC1 id=0xFF same cycle.
  -> Out id=0xFF.
- Flush priority: held valid, out_ready=1, flush=1, SIC0 valid same cycle.
  -> Next cycle out_valid=0. drop_cnt+1, since the SIC0 input is discarded and the accepted held entry is not counted.
- Sync reset mid-hold and saturation:
  - rst=1 with out_valid=1 -> out_valid=0, drop_cnt=0 after the edge.
  - With CNT_WIDTH=4, drive 20 drops -> drop_cnt=15.
